// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the execute stage and the multi-cycle mul/div sequencer.
interface muldiv_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  // Execute stage side: issues requests and stalls on busy.
  modport master (
    output start, op, a, b, flush,
    input  busy, done, result
  );

  // Sequencer side.
  modport slave (
    input  start, op, a, b, flush,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle sequencer for mul/div/rem: shift-add multiply and restoring divide on
// operand magnitudes, followed by a single sign-correction cycle and a one-cycle done pulse.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  muldiv_sequencer_if.slave  bus
);

  localparam logic [3:0] OpMul = 4'b1011;
  localparam logic [3:0] OpDiv = 4'b1100;
  localparam logic [3:0] OpRem = 4'b1101;

  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic             neg_q, neg_d;
  // acc holds the high product half (mul) or partial remainder (div); q holds the
  // multiplier/low product half (mul) or dividend/quotient (div); m is |b|.
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             op_valid;
  logic             is_divrem;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] fix_sel;

  // Decode of the incoming request and per-iteration datapath terms.
  always_comb begin
    op_valid  = (bus.op == OpMul) || (bus.op == OpDiv) || (bus.op == OpRem);
    is_divrem = (bus.op == OpDiv) || (bus.op == OpRem);
    mag_a     = bus.a[WIDTH-1] ? (~bus.a + 1'b1) : bus.a;
    mag_b     = bus.b[WIDTH-1] ? (~bus.b + 1'b1) : bus.b;
    mul_sum   = q_q[0] ? (acc_q + {1'b0, m_q}) : acc_q;
    rem_sh    = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    diff      = {1'b0, rem_sh} - {2'b00, m_q};
    fix_sel   = (op_q == OpRem) ? acc_q[WIDTH-1:0] : q_q;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    q_d      = q_q;
    m_d      = m_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.flush && op_valid) begin
          op_d  = bus.op;
          neg_d = (bus.op == OpRem) ? bus.a[WIDTH-1] : (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          acc_d = '0;
          q_d   = mag_a;
          m_d   = mag_b;
          cnt_d = CNT_W'(WIDTH);
          if (is_divrem && (bus.b == '0)) begin
            result_d = (bus.op == OpDiv) ? '1 : bus.a;
            state_d  = StDone;
          end else if (is_divrem && (bus.a == MinVal) && (bus.b == '1)) begin
            result_d = (bus.op == OpDiv) ? bus.a : '0;
            state_d  = StDone;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          if (op_q == OpMul) begin
            acc_d = {1'b0, mul_sum[WIDTH:1]};
            q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
          end else if (!diff[WIDTH+1]) begin
            acc_d = diff[WIDTH:0];
            q_d   = {q_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = rem_sh;
            q_d   = {q_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = StFix;
          end
        end
      end
      StFix: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          // Low WIDTH bits of the negated product equal the negated low half.
          result_d = neg_q ? (~fix_sel + 1'b1) : fix_sel;
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      q_q      <= '0;
      m_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      m_q      <= m_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q != StIdle);
  assign bus.done   = (state_q == StDone);
  assign bus.result = result_q;

endmodule
